fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..65535.
REQ-002 r_clk  input  1  single clock, the FIFO read-side clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tx_en  input  1  enables draining of the FIFO; sampled only in IDLE.
REQ-005 empty_flag  input  1  FIFO empty indication from the upstream FIFO read port.
REQ-006 fifo_data  input  8  FIFO read data, valid on the cycle after an r_en pulse.
REQ-007 r_en  output  1  FIFO read strobe, one cycle per byte.
REQ-008 tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 byte_done  output  1  one-cycle pulse marking end of a frame.

Function
REQ-011 States SHALL be IDLE, POP, WAIT, START, DATA, STOP; all outputs are registered or decoded from state only (no input-to-output combinational path).
REQ-012 IDLE -> POP when tx_en=1 and empty_flag=0 in the same cycle; otherwise remain IDLE.
REQ-013 POP lasts exactly 1 cycle with r_en=1; r_en=0 in every other state.
REQ-014 WAIT lasts exactly 1 cycle; fifo_data captured into an 8-bit shift register on the edge leaving WAIT.
REQ-015 START drives tx=0 for CLKS_PER_BIT cycles.
REQ-016 DATA drives shift-register bit 0 first, 8 bits, each for CLKS_PER_BIT cycles; 3-bit bit counter, clog2(CLKS_PER_BIT)-bit baud counter, both wrap to 0 at bit/state boundaries.
REQ-017 STOP drives tx=1 for CLKS_PER_BIT cycles; byte_done=1 during the last STOP cycle only; then -> IDLE.
REQ-018 tx=1 in IDLE, POP, WAIT.
REQ-019 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from first START cycle to last STOP cycle inclusive.
REQ-020 Continuous data (tx_en=1, empty_flag=0): successive r_en pulses SHALL be exactly 10*CLKS_PER_BIT+3 cycles apart.
REQ-021 tx_en or empty_flag changing after POP SHALL NOT affect the frame in progress; popped byte is always transmitted in full.
REQ-022 empty_flag=1 in IDLE: no r_en, busy=0, tx=1, indefinitely.
REQ-023 Byte value SHALL be transmitted unchanged; fifo_data changes after WAIT are ignored.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, tx=1, r_en=0, busy=0, byte_done=0, counters and shift register 0, on that edge, from any state.
REQ-025 Reset mid-frame SHALL abort the frame; the popped byte is discarded; no r_en before rst returns to 0.
REQ-026 After rst deasserts, first r_en no earlier than the cycle after IDLE sees tx_en=1, empty_flag=0.

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte: fifo_data=8'b10011001 after one r_en, tx_en=1, empty_flag low then high -> tx = 0,1,0,0,1,1,0,0,1,1 each held 4 cycles; byte_done pulse on cycle 40 of the frame; busy falls next cycle.
REQ-028 Eight bytes back-to-back (10011001, 11100001, 10011001, 11110000, repeated) -> 8 r_en pulses exactly 43 cycles apart; all frames bit-exact, LSB first.
REQ-029 empty_flag=1, tx_en=1 for 100 cycles -> r_en never asserted, tx=1, busy=0.
REQ-030 tx_en dropped mid-DATA of byte 11110000 -> frame completes correctly, then IDLE, no further r_en.
REQ-031 rst pulsed 1 cycle during DATA bit 3 -> next cycle tx=1, busy=0, r_en=0; after release with data available, new frame starts with fresh byte, start bit 4 cycles.
REQ-032 empty_flag rises during WAIT -> captured byte still transmitted; no second r_en.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from an upstream FIFO read port and sends each
// one as an 8N1 serial frame (LSB first, line idles high).
// Ports:
//   r_clk       FIFO read-side clock; all state changes on its rising edge
//   rst         synchronous active-high reset
//   tx_en       allows a new byte to be fetched; only looked at in IDLE
//   empty_flag  upstream FIFO empty indication
//   fifo_data   FIFO read data, valid the cycle after an r_en pulse
//   r_en        one-cycle FIFO read strobe per byte
//   tx          serial output line
//   busy        high whenever a byte is being fetched or sent
//   byte_done   one-cycle pulse on the last stop-bit cycle
// All outputs are registered, so no input reaches an output combinationally.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       r_clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       empty_flag,
  input  logic [7:0] fifo_data,
  output logic       r_en,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             r_en_q, r_en_d;
  logic             busy_q, busy_d;
  logic             byte_done_q, byte_done_d;
  logic             baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // Next-state, counters, shift register, and the output values for the next cycle
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;

    case (state_q)
      S_IDLE: begin
        if (tx_en && !empty_flag) begin
          state_d = S_POP;
        end
      end
      S_POP: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Read data is valid now; the byte is frozen here and later
        // changes on fifo_data are ignored.
        shreg_d = fifo_data;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        shreg_d = '0;
      end
    endcase

    // Outputs are derived from the next state so they line up with it once registered
    r_en_d      = (state_d == S_POP);
    busy_d      = (state_d != S_IDLE);
    byte_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    if (state_d == S_START) begin
      tx_d = 1'b0;
    end else if (state_d == S_DATA) begin
      tx_d = shreg_d[0];
    end else begin
      tx_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge r_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      tx_q        <= 1'b1;
      r_en_q      <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      r_en_q      <= r_en_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign tx        = tx_q;
  assign r_en      = r_en_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;

endmodule
